gray_rx: RTL and testbench

//   Receiving end of the Gray-code counter link: accepts Gray-coded samples,

---
 rtl/gray_pkg.sv | 27 ++
 rtl/gray2bin_comb.sv | 17 +
 rtl/gray_rx.sv | 137 +++++++++++++
 tb/tb_gray_rx.sv | 274 +++++++++++++++++++++++++++
 4 files changed

// File: rtl/gray_pkg.sv
// Shared Gray-code definitions: receiver FSM state encodings and
// reference gray/binary conversion helpers used by the Gray counter
// family and its benches.
package gray_pkg;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_TRACK = 2'd1,
        ST_FAULT = 2'd2
    } rx_state_t;

    // Gray to binary for any width up to 32; unused upper bits must be zero.
    function automatic logic [31:0] gray2bin(input logic [31:0] g);
        logic [31:0] b;
        b = '0;
        for (int i = 0; i < 32; i++) begin
            b[i] = ^(g >> i);
        end
        return b;
    endfunction

    // Binary to Gray for any width up to 32.
    function automatic logic [31:0] bin2gray(input logic [31:0] b);
        return b ^ (b >> 1);
    endfunction

endpackage

// File: rtl/gray2bin_comb.sv
// Purely combinational WIDTH-generic Gray-to-binary decoder.
module gray2bin_comb #(
    parameter int WIDTH = 3
) (
    input  logic [WIDTH-1:0] gray,
    output logic [WIDTH-1:0] bin
);

    // Each binary bit is the parity of the Gray bits at and above it.
    always_comb begin
        bin = '0;
        for (int i = 0; i < WIDTH; i++) begin
            bin[i] = ^(gray >> i);
        end
    end

endmodule

// File: rtl/gray_rx.sv
// Gray-code link receiver: decodes Gray samples to binary and checks that
// consecutive samples hold or advance by one, flagging step violations
// (StepErr pulse, Fault while in FAULT) and forward wrap (sticky Wrap).
// Optional feature macro: GRAY_RX_ERRCNT_EN adds the saturating ErrCnt port.
// Samples are captured at one edge and their results appear after the next.
module gray_rx
    import gray_pkg::*;
#(
    parameter int WIDTH = 3,
    parameter int ERRW  = 8
) (
    input  logic             Clk,
    input  logic             Reset,
    input  logic [WIDTH-1:0] In,
    input  logic             InValid,
    input  logic             Resync,
    output logic [WIDTH-1:0] Bin,
    output logic             BinValid,
    output logic             StepErr,
    output logic             Fault,
    output logic             Wrap
`ifdef GRAY_RX_ERRCNT_EN
    ,
    output logic [ERRW-1:0]  ErrCnt
`endif
);

    if (WIDTH < 2 || ERRW < 1) begin : g_bad_cfg
        $error("gray_rx: WIDTH must be >= 2 and ERRW >= 1");
    end

    localparam logic [WIDTH-1:0] STEP1 = WIDTH'(1);

    logic [WIDTH-1:0] in_p0;
    logic             vld_p0;
    logic             resync_p0;
    logic [WIDTH-1:0] bin_p1;
    logic [WIDTH-1:0] last;
    logic [WIDTH-1:0] delta;
    logic             bad_step;
    rx_state_t        state;

`ifdef GRAY_RX_ERRCNT_EN
    function automatic logic [ERRW-1:0] sat_inc(input logic [ERRW-1:0] v);
        return (&v) ? v : v + ERRW'(1);
    endfunction
`endif

    // ---- stage p0: capture sample ----
    // Capture the sample word; data path carries no reset.
    always_ff @(posedge Clk) begin
        in_p0 <= In;
    end

    // Capture sample qualifiers; reset drops any in-flight sample.
    always_ff @(posedge Clk) begin
        if (Reset) begin
            vld_p0    <= 1'b0;
            resync_p0 <= 1'b0;
        end else begin
            vld_p0    <= InValid;
            resync_p0 <= Resync;
        end
    end

    // ---- stage p1: decode, step check, registered outputs ----
    gray2bin_comb #(.WIDTH(WIDTH)) u_dec (
        .gray (in_p0),
        .bin  (bin_p1)
    );

    assign delta    = bin_p1 - last;
    assign bad_step = (delta != '0) && (delta != STEP1);

    // Tracking FSM with Last register, sticky flags and registered outputs.
    always_ff @(posedge Clk) begin
        if (Reset) begin
            state    <= ST_IDLE;
            last     <= '0;
            Bin      <= '0;
            BinValid <= 1'b0;
            StepErr  <= 1'b0;
            Fault    <= 1'b0;
            Wrap     <= 1'b0;
`ifdef GRAY_RX_ERRCNT_EN
            ErrCnt   <= '0;
`endif
        end else begin
            BinValid <= vld_p0;
            StepErr  <= 1'b0;
            if (vld_p0) begin
                Bin <= bin_p1;
            end
            if (resync_p0) begin
                // Resync decodes the sample but never checks or tracks it.
                state <= ST_IDLE;
                Fault <= 1'b0;
            end else if (vld_p0) begin
                unique case (state)
                    ST_IDLE: begin
                        state <= ST_TRACK;
                        last  <= bin_p1;
                    end
                    ST_TRACK: begin
                        if (delta == STEP1) begin
                            last <= bin_p1;
                            if (bin_p1 == '0) begin
                                Wrap <= 1'b1;
                            end
                        end else if (bad_step) begin
                            StepErr <= 1'b1;
                            last    <= bin_p1;
                            state   <= ST_FAULT;
                            Fault   <= 1'b1;
`ifdef GRAY_RX_ERRCNT_EN
                            ErrCnt  <= sat_inc(ErrCnt);
`endif
                        end
                    end
                    ST_FAULT: begin
                        last <= bin_p1;
`ifdef GRAY_RX_ERRCNT_EN
                        if (bad_step) begin
                            ErrCnt <= sat_inc(ErrCnt);
                        end
`endif
                    end
                    default: begin
                        state <= ST_IDLE;
                        Fault <= 1'b0;
                    end
                endcase
            end
        end
    end

endmodule

// File: tb/tb_gray_rx.sv
// Self-checking bench for gray_rx (WIDTH=3). A behavioural reference model
// pushes the expected output word for every driven cycle; after each clock
// edge the word from the previous cycle is popped and compared.
// Build with GRAY_RX_ERRCNT_EN defined to exercise ErrCnt with ERRW=2.
module tb_gray_rx;

    localparam int WIDTH = 3;
`ifdef GRAY_RX_ERRCNT_EN
    localparam int ERRW = 2;
`else
    localparam int ERRW = 8;
`endif

    typedef struct packed {
        logic [WIDTH-1:0] bin;
        logic             bv;
        logic             se;
        logic             fault;
        logic             wrap;
        logic [ERRW-1:0]  cnt;
    } exp_t;

    logic             Clk = 1'b0;
    logic             Reset;
    logic [WIDTH-1:0] In;
    logic             InValid;
    logic             Resync;
    logic [WIDTH-1:0] Bin;
    logic             BinValid;
    logic             StepErr;
    logic             Fault;
    logic             Wrap;
    logic [ERRW-1:0]  errcnt_w;

    int checks = 0;
    int errors = 0;
    int steperr_seen = 0;

    exp_t q[$];

    // reference model state
    int               m_state;   // 0 idle, 1 track, 2 fault
    logic [WIDTH-1:0] m_last;
    logic [WIDTH-1:0] m_bin;
    logic             m_fault;
    logic             m_wrap;
    logic [ERRW-1:0]  m_cnt;

    gray_rx #(.WIDTH(WIDTH), .ERRW(ERRW)) dut (
        .Clk      (Clk),
        .Reset    (Reset),
        .In       (In),
        .InValid  (InValid),
        .Resync   (Resync),
        .Bin      (Bin),
        .BinValid (BinValid),
        .StepErr  (StepErr),
        .Fault    (Fault),
        .Wrap     (Wrap)
`ifdef GRAY_RX_ERRCNT_EN
        ,
        .ErrCnt   (errcnt_w)
`endif
    );

`ifndef GRAY_RX_ERRCNT_EN
    assign errcnt_w = '0;
`endif

    always #5 Clk = ~Clk;

    function automatic logic [WIDTH-1:0] dec(input logic [WIDTH-1:0] g);
        logic [WIDTH-1:0] b;
        b[WIDTH-1] = g[WIDTH-1];
        for (int i = WIDTH - 2; i >= 0; i--) b[i] = b[i+1] ^ g[i];
        return b;
    endfunction

    task automatic model_reset();
        m_state = 0; m_last = '0; m_bin = '0;
        m_fault = 1'b0; m_wrap = 1'b0; m_cnt = '0;
        q.delete();
    endtask

    task automatic compare_front();
        exp_t e;
        exp_t a;
        e = q.pop_front();
        a = '{bin: Bin, bv: BinValid, se: StepErr, fault: Fault, wrap: Wrap, cnt: errcnt_w};
        if (StepErr === 1'b1) steperr_seen++;
        checks++;
        if (a !== e) begin
            errors++;
            $display("FAIL out t=%0t got Bin=%0d BV=%b SE=%b F=%b W=%b Cnt=%0d want Bin=%0d BV=%b SE=%b F=%b W=%b Cnt=%0d",
                     $time, a.bin, a.bv, a.se, a.fault, a.wrap, a.cnt,
                     e.bin, e.bv, e.se, e.fault, e.wrap, e.cnt);
        end
    endtask

    // Drive one cycle, advance the model, check the previous cycle's result.
    task automatic step(input logic v, input logic [WIDTH-1:0] g, input logic rs);
        logic [WIDTH-1:0] b;
        logic [WIDTH-1:0] d;
        logic             se;
        In = g; InValid = v; Resync = rs;
        b  = dec(g);
        d  = b - m_last;
        se = 1'b0;
        if (v) m_bin = b;
        if (rs) begin
            m_state = 0; m_fault = 1'b0;
        end else if (v) begin
            if (m_state == 0) begin
                m_state = 1; m_last = b;
            end else if (m_state == 1) begin
                if (d == 3'd1) begin
                    if (b == 3'd0) m_wrap = 1'b1;
                    m_last = b;
                end else if (d != 3'd0) begin
                    se = 1'b1; m_last = b; m_state = 2; m_fault = 1'b1;
`ifdef GRAY_RX_ERRCNT_EN
                    if (m_cnt != {ERRW{1'b1}}) m_cnt = m_cnt + 1'b1;
`endif
                end
            end else begin
`ifdef GRAY_RX_ERRCNT_EN
                if (d != 3'd0 && d != 3'd1 && m_cnt != {ERRW{1'b1}}) m_cnt = m_cnt + 1'b1;
`endif
                m_last = b;
            end
        end
        q.push_back('{bin: m_bin, bv: v, se: se, fault: m_fault, wrap: m_wrap, cnt: m_cnt});
        @(posedge Clk);
        #1;
        if (q.size() >= 2) compare_front();
    endtask

    task automatic drain();
        step(1'b0, 3'b000, 1'b0);
        step(1'b0, 3'b000, 1'b0);
    endtask

    task automatic do_reset();
        Reset = 1'b1; InValid = 1'b0; Resync = 1'b0; In = '0;
        @(posedge Clk);
        #1;
        Reset = 1'b0;
        model_reset();
        checks++;
        if ({Bin, BinValid, StepErr, Fault, Wrap, errcnt_w} !== '0) begin
            errors++;
            $display("FAIL reset_outputs got Bin=%0d BV=%b SE=%b F=%b W=%b Cnt=%0d want all zero",
                     Bin, BinValid, StepErr, Fault, Wrap, errcnt_w);
        end
    endtask

    task automatic test_reset();
        do_reset();
        drain();
    endtask

    task automatic test_full_sequence();
        logic [WIDTH-1:0] seq [9] = '{3'b000, 3'b001, 3'b011, 3'b010, 3'b110,
                                      3'b111, 3'b101, 3'b100, 3'b000};
        int se0;
        se0 = steperr_seen;
        for (int i = 0; i < 9; i++) step(1'b1, seq[i], 1'b0);
        drain();
        checks++;
        if (Wrap !== 1'b1 || steperr_seen != se0) begin
            errors++;
            $display("FAIL full_seq_wrap got Wrap=%b stepErrs=%0d want Wrap=1 stepErrs=0",
                     Wrap, steperr_seen - se0);
        end
    endtask

    task automatic test_hold();
        step(1'b0, 3'b000, 1'b1);
        step(1'b1, 3'b011, 1'b0);
        step(1'b1, 3'b011, 1'b0);
        step(1'b1, 3'b011, 1'b0);
        step(1'b1, 3'b010, 1'b0);
        drain();
        checks++;
        if (Bin !== 3'd3 || Fault !== 1'b0) begin
            errors++;
            $display("FAIL hold_end got Bin=%0d Fault=%b want Bin=3 Fault=0", Bin, Fault);
        end
    endtask

    task automatic test_step_err();
        int se0;
        se0 = steperr_seen;
        step(1'b0, 3'b000, 1'b1);
        step(1'b1, 3'b000, 1'b0);
        step(1'b1, 3'b001, 1'b0);
        step(1'b1, 3'b010, 1'b0);
        step(1'b0, 3'b000, 1'b1);
        step(1'b1, 3'b110, 1'b0);
        step(1'b1, 3'b111, 1'b0);
        drain();
        checks++;
        if (steperr_seen - se0 != 1 || Fault !== 1'b0) begin
            errors++;
            $display("FAIL step_err_pulses got %0d Fault=%b want 1 Fault=0",
                     steperr_seen - se0, Fault);
        end
    endtask

    task automatic test_gaps();
        step(1'b0, 3'b000, 1'b1);
        step(1'b1, 3'b000, 1'b0);
        step(1'b1, 3'b001, 1'b0);
        step(1'b0, 3'b111, 1'b0);
        step(1'b0, 3'b110, 1'b0);
        step(1'b0, 3'b101, 1'b0);
        checks++;
        if (Bin !== 3'd1 || BinValid !== 1'b0) begin
            errors++;
            $display("FAIL gap_hold got Bin=%0d BV=%b want Bin=1 BV=0", Bin, BinValid);
        end
        step(1'b1, 3'b011, 1'b0);
        drain();
    endtask

    task automatic test_reset_midstream();
        step(1'b0, 3'b000, 1'b1);
        step(1'b1, 3'b101, 1'b0);
        step(1'b1, 3'b100, 1'b0);
        step(1'b1, 3'b000, 1'b0);
        step(1'b1, 3'b011, 1'b0);
        step(1'b1, 3'b010, 1'b0);
        checks++;
        if (Wrap !== 1'b1 || Fault !== 1'b1) begin
            errors++;
            $display("FAIL pre_reset_flags got Wrap=%b Fault=%b want 1 1", Wrap, Fault);
        end
        do_reset();
        step(1'b1, 3'b101, 1'b0);
        step(1'b1, 3'b100, 1'b0);
        drain();
    endtask

`ifdef GRAY_RX_ERRCNT_EN
    task automatic test_errcnt();
        logic [WIDTH-1:0] seq [6] = '{3'b000, 3'b011, 3'b110, 3'b101, 3'b000, 3'b011};
        do_reset();
        for (int i = 0; i < 6; i++) step(1'b1, seq[i], 1'b0);
        drain();
        checks++;
        if (errcnt_w !== 2'd3) begin
            errors++;
            $display("FAIL errcnt_sat got %0d want 3", errcnt_w);
        end
    endtask
`endif

    initial begin
        Reset = 1'b1; In = '0; InValid = 1'b0; Resync = 1'b0;
        model_reset();
        test_reset();
        test_full_sequence();
        test_hold();
        test_step_err();
        test_gaps();
        test_reset_midstream();
`ifdef GRAY_RX_ERRCNT_EN
        test_errcnt();
`endif
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
